// File: rtl/change_dispenser.sv
// Greedy coin payout: captures change on start, offers one coin per valid/ack handshake (stalls hold), pulses done.
// First coin the cycle after start; done the cycle after the last ack. CHANGE_DISPENSER_TALLY_EN adds per-coin tallies.
module change_dispenser #(
   parameter int COIN_HI  = 10,
   parameter int COIN_MID = 5,
   parameter int COIN_LO  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] change,
   output logic       busy,
   output logic       coin_valid,
   output logic [1:0] coin_sel,
   input  logic       coin_ack,
`ifdef CHANGE_DISPENSER_TALLY_EN
   output logic [2:0] tally_hi,
   output logic [2:0] tally_mid,
   output logic [2:0] tally_lo,
`endif
   output logic       done
);

   localparam logic [4:0] HI_V  = 5'(COIN_HI);
   localparam logic [4:0] MID_V = 5'(COIN_MID);
   localparam logic [4:0] LO_V  = 5'(COIN_LO);

   localparam logic [1:0] SEL_HI  = 2'b11;
   localparam logic [1:0] SEL_MID = 2'b10;
   localparam logic [1:0] SEL_LO  = 2'b01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [4:0] remaining;
   logic [4:0] remaining_nxt;
   logic [1:0] pick_sel;
   logic [4:0] pick_val;
   logic       xfer;

   // Greedy pick from the registered amount only, so coin_sel never depends on inputs.
   always_comb begin
      pick_sel = SEL_LO;
      pick_val = LO_V;
      if (remaining >= HI_V) begin
         pick_sel = SEL_HI;
         pick_val = HI_V;
      end else if (remaining >= MID_V) begin
         pick_sel = SEL_MID;
         pick_val = MID_V;
      end
   end

   assign xfer = (state == OFFER) && coin_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= 5'd0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      busy          = 1'b0;
      coin_valid    = 1'b0;
      coin_sel      = 2'b00;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               remaining_nxt = change;
               state_nxt     = (change == 5'd0) ? DONE : OFFER;
            end
         end
         OFFER: begin
            busy       = 1'b1;
            coin_valid = 1'b1;
            coin_sel   = pick_sel;
            if (coin_ack) begin
               // Greedy pick is always <= remaining, so this cannot wrap.
               remaining_nxt = remaining - pick_val;
               if (remaining_nxt == 5'd0) state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef CHANGE_DISPENSER_TALLY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tally_hi  <= 3'd0;
         tally_mid <= 3'd0;
         tally_lo  <= 3'd0;
      end else if (state == IDLE && start) begin
         tally_hi  <= 3'd0;
         tally_mid <= 3'd0;
         tally_lo  <= 3'd0;
      end else if (xfer) begin
         case (pick_sel)
            SEL_HI:  tally_hi  <= tally_hi + 3'd1;
            SEL_MID: tally_mid <= tally_mid + 3'd1;
            default: tally_lo  <= tally_lo + 3'd1;
         endcase
      end
   end
`endif

endmodule
